mem_access_ctrl: RTL and testbench

- Multi-cycle load/store sequencer between the MEM stage and a word-wide, handshaked data memory.
- Accepts one access at a time with size DAOp (word/half/byte) and sign select SSel.
- Sub-word stores use read-modify-write; loads are extracted and sign/zero-extended.
- Raises busy to stall the pipeline and pulses done with the result or an error flag.

---
 rtl/mem_access_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle load/store sequencer between the MEM stage and
// a word-wide handshaked data memory. Accepts one access at a time, performs
// read-modify-write for sub-word stores, extracts and extends sub-word loads,
// and reports completion with a one-cycle done pulse plus an error flag.
//
// Optional feature macro: MEM_BYTE_ENABLE_EN
//   defined   : sub-word stores go straight to WR using lane replication and
//               byte enables instead of read-modify-write.
//   undefined : read-modify-write for sub-word stores, mem_be fixed at 4'hF.
module mem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        DAOp,
   input  logic              SSel,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // A zero TIMEOUT disables the watchdog entirely (wait forever).
   localparam bit          TMO_EN    = (TIMEOUT > 0);
   localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);

   // Alignment rule: words need addr[1:0]==0, halves need addr[0]==0.
   function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] off);
      logic res;
      res = 1'b0;
      case (op)
         2'b00:   res = (off != 2'b00);
         2'b01:   res = off[0];
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Pick the addressed lane out of the read word and sign/zero-extend it.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  op,
                                                input logic        sext,
                                                input logic [1:0]  off);
      logic [15:0] half;
      logic [7:0]  byt;
      logic [31:0] res;
      half = off[1] ? word[31:16] : word[15:0];
      case (off)
         2'b00:   byt = word[7:0];
         2'b01:   byt = word[15:8];
         2'b10:   byt = word[23:16];
         default: byt = word[31:24];
      endcase
      case (op)
         2'b00:   res = word;
         2'b01:   res = {{16{sext & half[15]}}, half};
         default: res = {{24{sext & byt[7]}}, byt};
      endcase
      return res;
   endfunction

   // Overlay the right-aligned store data onto the read word at the lane
   // selected by the offset; all other lanes keep their old contents.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [15:0] data,
                                               input logic [1:0]  op,
                                               input logic [1:0]  off);
      logic [31:0] res;
      res = word;
      case (op)
         2'b00: res = word;
         2'b01: res = off[1] ? {data, word[15:0]} : {word[31:16], data};
         default: begin
            case (off)
               2'b00:   res = {word[31:8], data[7:0]};
               2'b01:   res = {word[31:16], data[7:0], word[7:0]};
               2'b10:   res = {word[31:24], data[7:0], word[15:0]};
               default: res = {data[7:0], word[23:0]};
            endcase
         end
      endcase
      return res;
   endfunction

`ifdef MEM_BYTE_ENABLE_EN
   // Replicate a sub-word across all lanes so any enabled lane sees it.
   function automatic logic [31:0] lane_replicate(input logic [15:0] data,
                                                  input logic [1:0]  op);
      logic [31:0] res;
      case (op)
         2'b00:   res = 32'h0000_0000;
         2'b01:   res = {data, data};
         default: res = {4{data[7:0]}};
      endcase
      return res;
   endfunction

   // Byte enables for a sub-word store at the given offset.
   function automatic logic [3:0] lane_enable(input logic [1:0] op,
                                              input logic [1:0] off);
      logic [3:0] res;
      case (op)
         2'b00:   res = 4'hF;
         2'b01:   res = off[1] ? 4'b1100 : 4'b0011;
         default: res = 4'b0001 << off;
      endcase
      return res;
   endfunction
`endif

   state_t              state_q,     state_d;
   logic                we_q,        we_d;
   logic [1:0]          daop_q,      daop_d;
   logic                ssel_q,      ssel_d;
   logic [1:0]          off_q,       off_d;
   logic [15:0]         sub_q,       sub_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic [3:0]          mem_be_q,    mem_be_d;
   logic [31:0]         rdata_q,     rdata_d;
   logic                err_q,       err_d;
   logic [31:0]         tmo_q,       tmo_d;
   logic                tmo_hit_s;

   // Watchdog fires when this waiting cycle would bring the count to TIMEOUT.
   always_comb begin
      tmo_hit_s = 1'b0;
      if (TMO_EN) begin
         tmo_hit_s = ((tmo_q + 32'd1) >= TMO_LIMIT);
      end else begin
         tmo_hit_s = 1'b0;
      end
   end

   // Next-state and datapath update for the access sequencer.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      daop_d      = daop_q;
      ssel_d      = ssel_q;
      off_d       = off_q;
      sub_d       = sub_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d       = we;
               daop_d     = DAOp;
               ssel_d     = SSel;
               off_d      = addr[1:0];
               sub_d      = wdata[15:0];
               mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
               mem_be_d   = 4'hF;
               tmo_d      = 32'd0;
               err_d      = 1'b0;
               if (is_misaligned(DAOp, addr[1:0])) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else if (we && (DAOp == 2'b00)) begin
                  state_d     = S_WR;
                  mem_wdata_d = wdata;
               end else if (we) begin
`ifdef MEM_BYTE_ENABLE_EN
                  state_d     = S_WR;
                  mem_wdata_d = lane_replicate(wdata[15:0], DAOp);
                  mem_be_d    = lane_enable(DAOp, addr[1:0]);
`else
                  state_d     = S_RD;
`endif
               end else begin
                  state_d = S_RD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            if (mem_ready) begin
               if (we_q) begin
                  mem_wdata_d = store_merge(mem_rdata, sub_q, daop_q, off_q);
                  tmo_d       = 32'd0;
                  state_d     = S_WR;
               end else begin
                  rdata_d = load_extract(mem_rdata, daop_q, ssel_q, off_q);
                  state_d = S_DONE;
               end
            end else if (tmo_hit_s) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         S_WR: begin
            if (mem_ready) begin
               state_d = S_DONE;
            end else if (tmo_hit_s) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            err_d   = 1'b0;
         end
      endcase
   end

   // State and datapath registers; synchronous active-low reset abandons any access.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         daop_q      <= 2'b00;
         ssel_q      <= 1'b0;
         off_q       <= 2'b00;
         sub_q       <= 16'h0000;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0000_0000;
         mem_be_q    <= 4'hF;
         rdata_q     <= 32'h0000_0000;
         err_q       <= 1'b0;
         tmo_q       <= 32'd0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         daop_q      <= daop_d;
         ssel_q      <= ssel_d;
         off_q       <= off_d;
         sub_q       <= sub_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
      end
   end

   // Handshake and status outputs decode directly from the state register.
   always_comb begin
      mem_req   = (state_q == S_RD) || (state_q == S_WR);
      mem_we    = (state_q == S_WR);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      err       = err_q;
      rdata     = rdata_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      mem_be    = mem_be_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl. Two instances share the
// stimulus: one waits forever (TIMEOUT=0), one gives up after 3 stalled cycles.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset, req, we, SSel, mem_ready;
   logic [1:0]  DAOp;
   logic [31:0] addr, wdata, mem_rdata;

   logic        mem_req, mem_we, busy, done, err;
   logic [31:0] mem_addr, mem_wdata, rdata;
   logic [3:0]  mem_be;

   logic        mem_req_t, mem_we_t, busy_t, done_t, err_t;
   logic [31:0] mem_addr_t, mem_wdata_t, rdata_t;
   logic [3:0]  mem_be_t;

   int n_checks = 0;
   int n_fail   = 0;

   // results captured by wait_done
   int          lat, wr_cnt;
   logic        saw_req, err_c;
   logic [31:0] wr_data, wr_addr, rdata_c;
   logic [3:0]  wr_be;

   localparam logic [31:0] LAST_LOAD = 32'h80FF7F01;
`ifdef MEM_BYTE_ENABLE_EN
   localparam logic [31:0] H_DATA = 32'hABCDABCD;
   localparam logic [3:0]  H_BE   = 4'b1100;
   localparam logic [31:0] B_DATA = 32'h5A5A5A5A;
   localparam logic [3:0]  B_BE   = 4'b0010;
   localparam int          SUB_LAT = 1;
`else
   localparam logic [31:0] H_DATA = 32'hABCD3344;
   localparam logic [3:0]  H_BE   = 4'hF;
   localparam logic [31:0] B_DATA = 32'h11225A44;
   localparam logic [3:0]  B_BE   = 4'hF;
   localparam int          SUB_LAT = 2;
`endif

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(0)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .DAOp(DAOp), .SSel(SSel),
      .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done),
      .err(err), .rdata(rdata));

   mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(3)) dut_t (
      .clk(clk), .reset(reset), .req(req), .we(we), .DAOp(DAOp), .SSel(SSel),
      .addr(addr), .wdata(wdata), .mem_req(mem_req_t), .mem_we(mem_we_t),
      .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_be(mem_be_t),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy_t), .done(done_t),
      .err(err_t), .rdata(rdata_t));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [1:0] op, input logic s,
                        input logic [31:0] a, input logic [31:0] d);
      we = w; DAOp = op; SSel = s; addr = a; wdata = d; req = 1'b1;
      tick;
      req = 1'b0;
   endtask

   // Wait (bounded) for done on the main instance, recording the memory traffic,
   // then step past the DONE cycle.
   task automatic wait_done;
      lat = 0; wr_cnt = 0; saw_req = 1'b0;
      while (!done && lat < 20) begin
         if (mem_req) saw_req = 1'b1;
         if (mem_req && mem_we && mem_ready) begin
            wr_cnt++; wr_data = mem_wdata; wr_be = mem_be; wr_addr = mem_addr;
         end
         tick;
         lat++;
      end
      check_eq("done_seen", 32'(done), 32'd1);
      err_c = err;
      rdata_c = rdata;
      tick;
   endtask

   task automatic run_load(input string tag, input logic [1:0] op, input logic s,
                           input logic [31:0] a, input logic [31:0] exp);
      issue(1'b0, op, s, a, 32'h0);
      wait_done;
      check_eq({tag, "_lat"},  32'(lat), 32'd1);
      check_eq({tag, "_data"}, rdata_c, exp);
      check_eq({tag, "_err"},  32'(err_c), 32'd0);
   endtask

   task automatic run_store(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_d,
                            input logic [3:0] exp_be, input int exp_lat);
      issue(1'b1, op, 1'b0, a, d);
      wait_done;
      check_eq({tag, "_lat"},  32'(lat), 32'(exp_lat));
      check_eq({tag, "_wcnt"}, 32'(wr_cnt), 32'd1);
      check_eq({tag, "_wdat"}, wr_data, exp_d);
      check_eq({tag, "_be"},   32'(wr_be), 32'(exp_be));
      check_eq({tag, "_addr"}, wr_addr, {a[31:2], 2'b00});
      check_eq({tag, "_err"},  32'(err_c), 32'd0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t_done_at;
      logic t_err, t_wr, stable, seen;

      reset = 1'b0; req = 1'b0; we = 1'b0; DAOp = 2'b00; SSel = 1'b0;
      addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b1;
      tick; tick;
      check_eq("rst_busy",  32'(busy), 32'd0);
      check_eq("rst_mreq",  32'(mem_req), 32'd0);
      check_eq("rst_mwe",   32'(mem_we), 32'd0);
      check_eq("rst_done",  32'(done), 32'd0);
      check_eq("rst_err",   32'(err), 32'd0);
      check_eq("rst_rdata", rdata, 32'h0);
      check_eq("rst_maddr", mem_addr, 32'h0);
      check_eq("rst_mwdat", mem_wdata, 32'h0);
      check_eq("rst_be",    32'(mem_be), 32'hF);
      reset = 1'b1;
      tick;

      // loads from word 80FF7F01
      mem_rdata = 32'h80FF7F01;
      run_load("ldb_s2", 2'b10, 1'b1, 32'h0000_1002, 32'hFFFFFFFF);
      run_load("ldb_z2", 2'b10, 1'b0, 32'h0000_1002, 32'h000000FF);
      run_load("ldb_s3", 2'b11, 1'b1, 32'h0000_1003, 32'hFFFFFF80);
      run_load("ldb_s1", 2'b10, 1'b1, 32'h0000_1001, 32'h0000007F);
      run_load("ldh_s2", 2'b01, 1'b1, 32'h0000_1002, 32'hFFFF80FF);
      run_load("ldh_z2", 2'b01, 1'b0, 32'h0000_1002, 32'h000080FF);
      run_load("ldh_s0", 2'b01, 1'b1, 32'h0000_1000, 32'h00007F01);
      run_load("ldw",    2'b00, 1'b1, 32'h0000_1004, LAST_LOAD);

      // misaligned accesses: immediate error, no memory request
      issue(1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0);
      wait_done;
      check_eq("mis_w_lat", 32'(lat), 32'd0);
      check_eq("mis_w_err", 32'(err_c), 32'd1);
      check_eq("mis_w_req", 32'(saw_req), 32'd0);
      issue(1'b1, 2'b01, 1'b0, 32'h0000_1003, 32'h1234);
      wait_done;
      check_eq("mis_h_lat", 32'(lat), 32'd0);
      check_eq("mis_h_err", 32'(err_c), 32'd1);
      check_eq("mis_h_wr",  32'(wr_cnt), 32'd0);
      check_eq("mis_h_req", 32'(saw_req), 32'd0);

      // stores against word 11223344
      mem_rdata = 32'h11223344;
      run_store("sth", 2'b01, 32'h0000_2002, 32'h0000ABCD, H_DATA, H_BE, SUB_LAT);
      run_store("stb", 2'b10, 32'h0000_2001, 32'hFFFFFF5A, B_DATA, B_BE, SUB_LAT);
      run_store("stw", 2'b00, 32'h0000_2004, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 1);

      // stalled load: main instance waits, timeout instance gives up
      mem_ready = 1'b0; mem_rdata = 32'h0;
      issue(1'b0, 2'b00, 1'b0, 32'h0000_1008, 32'h0);
      t_done_at = 0; t_err = 1'b0; stable = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         if (!busy || !mem_req || mem_we || done || mem_addr !== 32'h1008) stable = 1'b0;
         if (done_t && t_done_at == 0) begin t_done_at = i; t_err = err_t; end
         tick;
      end
      check_eq("stl_stable", 32'(stable), 32'd1);
      check_eq("stl_t_at",   32'(t_done_at), 32'd4);
      check_eq("stl_t_err",  32'(t_err), 32'd1);
      check_eq("stl_t_rdat", rdata_t, LAST_LOAD);
      mem_rdata = 32'hCAFEF00D; mem_ready = 1'b1;
      check_eq("stl_pre",    32'(done), 32'd0);
      tick;
      check_eq("stl_done",   32'(done), 32'd1);
      check_eq("stl_err",    32'(err), 32'd0);
      check_eq("stl_rdata",  rdata, 32'hCAFEF00D);
      tick;

`ifndef MEM_BYTE_ENABLE_EN
      // stalled read-modify-write store: timeout must not reach WR
      mem_ready = 1'b0; mem_rdata = 32'h11223344;
      issue(1'b1, 2'b10, 1'b0, 32'h0000_3001, 32'h0000005A);
      t_done_at = 0; t_err = 1'b0; t_wr = 1'b0; stable = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         if (mem_we_t) t_wr = 1'b1;
         if (!busy || mem_we || mem_addr !== 32'h3000) stable = 1'b0;
         if (done_t && t_done_at == 0) begin t_done_at = i; t_err = err_t; end
         tick;
      end
      check_eq("sts_stable", 32'(stable), 32'd1);
      check_eq("sts_t_at",   32'(t_done_at), 32'd4);
      check_eq("sts_t_err",  32'(t_err), 32'd1);
      check_eq("sts_t_wr",   32'(t_wr), 32'd0);
      mem_ready = 1'b1;
      tick;
      check_eq("sts_we",     32'(mem_we), 32'd1);
      check_eq("sts_wdat",   mem_wdata, 32'h11225A44);
      tick;
      check_eq("sts_done",   32'(done), 32'd1);
      check_eq("sts_err",    32'(err), 32'd0);
      tick;
`endif

      // reset in the middle of a read phase
      mem_ready = 1'b0;
      issue(1'b0, 2'b00, 1'b0, 32'h0000_100C, 32'h0);
      tick;
      check_eq("mr_busy_pre", 32'(busy), 32'd1);
      reset = 1'b0;
      tick; tick;
      check_eq("mr_busy",  32'(busy), 32'd0);
      check_eq("mr_mreq",  32'(mem_req), 32'd0);
      check_eq("mr_rdata", rdata, 32'h0);
      check_eq("mr_t_busy", 32'(busy_t), 32'd0);
      reset = 1'b1; mem_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (done || done_t) seen = 1'b1;
         tick;
      end
      check_eq("mr_no_done", 32'(seen), 32'd0);
      mem_rdata = 32'h0BADF00D;
      run_load("post_rst", 2'b00, 1'b0, 32'h0000_100C, 32'h0BADF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
